// File: rtl/fft_stage_sequencer.sv
// Stage/butterfly address sequencer for an in-place radix-2 DIF FFT.
// Issues one butterfly read per cycle, tracks reads through a fixed-latency
// delay line to produce the write-back strobes, and drains between stages so
// the next stage never reads a location before the previous stage wrote it.
module fft_stage_sequencer #(
    parameter int unsigned N          = 64,
    parameter int unsigned LOG2N      = 6,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned BF_LATENCY = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             bf_out_valid,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_addr,
    output logic             bf_enable,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned KW = LOG2N - 1;
    localparam int unsigned SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
    localparam int unsigned D  = RD_LATENCY + BF_LATENCY;
    localparam int unsigned CW = ($clog2(D) > 0) ? $clog2(D) : 1;

    localparam logic [KW-1:0] KLast   = KW'(N / 2 - 1);
    localparam logic [SW-1:0] SLast   = SW'(LOG2N - 1);
    localparam logic [CW-1:0] DLast   = CW'(D - 1);
    localparam logic [KW-1:0] MaskAll = '1;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFinish} state_t;

    state_t        state_q;
    logic [SW-1:0] s_q;
    logic [KW-1:0] k_q;
    logic [CW-1:0] drain_q;

    // Delay line: valid plus both write-back addresses, one slot per cycle of latency.
    logic [D-1:0]     vld_q;
    logic [LOG2N-1:0] pa_q [D];
    logic [LOG2N-1:0] pb_q [D];

    logic             err_q;

    logic [KW-1:0]    mask;
    logic [KW-1:0]    pos;
    logic [KW-1:0]    hi;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic [KW-1:0]    tw;

    // Sequencer FSM: stage/butterfly counters and drain timing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            s_q     <= '0;
            k_q     <= '0;
            drain_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StIssue;
                        s_q     <= '0;
                        k_q     <= '0;
                    end
                end
                StIssue: begin
                    if (k_q == KLast) begin
                        state_q <= StDrain;
                        drain_q <= '0;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                StDrain: begin
                    // Last write of this stage lands in the final drain cycle.
                    if (drain_q == DLast) begin
                        if (s_q == SLast) begin
                            state_q <= StFinish;
                        end else begin
                            state_q <= StIssue;
                            s_q     <= s_q + SW'(1);
                            k_q     <= '0;
                        end
                    end else begin
                        drain_q <= drain_q + CW'(1);
                    end
                end
                StFinish: state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    // Butterfly address generation: insert a zero bit into k at the span position.
    always_comb begin
        mask   = MaskAll >> s_q;          // span - 1
        pos    = k_q & mask;
        hi     = k_q & ~mask;
        addr_a = {hi, 1'b0} | {1'b0, pos};
        span   = {1'b0, mask} + LOG2N'(1);
        addr_b = addr_a | span;
        tw     = pos << s_q;

        rd_en     = (state_q == StIssue);
        rd_addr_a = rd_en ? addr_a : '0;
        rd_addr_b = rd_en ? addr_b : '0;
        tw_addr   = rd_en ? tw : '0;
    end

    // Read-to-write delay line; addresses are already zeroed when rd_en is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < int'(D); i++) begin
                pa_q[i] <= '0;
                pb_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_en;
            pa_q[0]  <= rd_addr_a;
            pb_q[0]  <= rd_addr_b;
            for (int i = 1; i < int'(D); i++) begin
                vld_q[i] <= vld_q[i-1];
                pa_q[i]  <= pa_q[i-1];
                pb_q[i]  <= pb_q[i-1];
            end
        end
    end

    // Sticky flag: butterfly output valid must track the delay-line valid exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | (bf_out_valid != vld_q[D-1]);
        end
    end

    assign bf_enable = vld_q[RD_LATENCY-1];
    assign wr_en     = vld_q[D-1];
    assign wr_addr_a = pa_q[D-1];
    assign wr_addr_b = pb_q[D-1];
    assign busy      = (state_q == StIssue) || (state_q == StDrain);
    assign done      = (state_q == StFinish);
    assign err       = err_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer: per-cycle trace compared against
// a schedule computed from the stage/butterfly arithmetic, plus fixed spot checks.
module tb_fft_stage_sequencer;

    localparam int N     = 64;
    localparam int LOG2N = 6;
    localparam int RDL   = 1;
    localparam int BFL   = 3;
    localparam int D     = RDL + BFL;
    localparam int HALF  = N / 2;
    localparam int L     = LOG2N * (HALF + D) + 1;   // relative cycle of done
    localparam int MAXC  = L + 8;
    localparam int TW    = 34;

    logic             clk = 1'b0;
    logic             reset, start, bf_out_valid;
    logic             rd_en, bf_enable, wr_en, busy, done, err;
    logic [LOG2N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [LOG2N-2:0] tw_addr;

    fft_stage_sequencer #(
        .N(N), .LOG2N(LOG2N), .RD_LATENCY(RDL), .BF_LATENCY(BFL)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .bf_out_valid(bf_out_valid),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
        .bf_enable(bf_enable), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit err_exp = 1'b0;

    // Expected schedule, indexed by cycle relative to the start-sampling cycle.
    bit         e_rd [MAXC], e_bfen [MAXC], e_wr [MAXC], e_busy [MAXC], e_done [MAXC];
    logic [5:0] e_a [MAXC], e_b [MAXC], e_wa [MAXC], e_wb [MAXC];
    logic [4:0] e_tw [MAXC];

    // Recorded DUT behaviour of the most recent run.
    bit         r_rd [MAXC], r_wr [MAXC], r_done [MAXC];
    logic [5:0] r_a [MAXC], r_b [MAXC], r_wa [MAXC], r_wb [MAXC];
    logic [4:0] r_tw [MAXC];
    int         rd_q[$], wr_q[$];

    function automatic logic [TW-1:0] act_vec();
        return {rd_en, rd_addr_a, rd_addr_b, tw_addr, bf_enable, wr_en,
                wr_addr_a, wr_addr_b, busy, done};
    endfunction

    task automatic build_model();
        for (int c = 0; c < MAXC; c++) begin
            e_rd[c] = 0; e_bfen[c] = 0; e_wr[c] = 0; e_busy[c] = 0; e_done[c] = 0;
            e_a[c] = 0; e_b[c] = 0; e_wa[c] = 0; e_wb[c] = 0; e_tw[c] = 0;
        end
        for (int s = 0; s < LOG2N; s++) begin
            for (int k = 0; k < HALF; k++) begin
                int span, pos, grp, a, c;
                span = N >> (s + 1);
                pos  = k % span;
                grp  = k / span;
                a    = grp * 2 * span + pos;
                c    = 1 + s * (HALF + D) + k;
                e_rd[c] = 1; e_a[c] = 6'(a); e_b[c] = 6'(a + span); e_tw[c] = 5'(pos << s);
                e_bfen[c + RDL] = 1;
                e_wr[c + D] = 1; e_wa[c + D] = 6'(a); e_wb[c + D] = 6'(a + span);
            end
        end
        for (int c = 1; c < L; c++) e_busy[c] = 1;
        e_done[L] = 1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            checks++;
            if (act_vec() !== '0) begin
                errors++;
                $display("FAIL idle: outputs=%h required=0", act_vec());
            end
            checks++;
            if (err !== err_exp) begin
                errors++;
                $display("FAIL idle_err: err=%b required=%b", err, err_exp);
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1; start = 1'b0; bf_out_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        err_exp = 1'b0;
        checks++;
        if ({act_vec(), err} !== '0) begin
            errors++;
            $display("FAIL reset_state: outputs=%h err=%b required all 0", act_vec(), err);
        end
    endtask

    // Called at #1 after an edge; drives start in this cycle and checks every
    // following cycle against the model. reset_at < 0 disables the abort.
    task automatic run_fft(input bit hold, input int drop_at, input int reset_at);
        logic [TW-1:0] exp_v;
        build_model();
        rd_q.delete(); wr_q.delete();
        for (int c = 0; c < MAXC; c++) begin
            r_rd[c] = 0; r_wr[c] = 0; r_done[c] = 0;
            r_a[c] = 0; r_b[c] = 0; r_wa[c] = 0; r_wb[c] = 0; r_tw[c] = 0;
        end
        start = 1'b1;
        for (int rel = 1; rel <= L + 3; rel++) begin
            @(posedge clk); #1;
            if (reset_at >= 0 && rel > reset_at) exp_v = '0;
            else exp_v = {e_rd[rel], e_a[rel], e_b[rel], e_tw[rel], e_bfen[rel], e_wr[rel],
                          e_wa[rel], e_wb[rel], e_busy[rel], e_done[rel]};
            checks++;
            if (act_vec() !== exp_v) begin
                errors++;
                $display("FAIL trace rel=%0d: outputs=%h required=%h", rel, act_vec(), exp_v);
            end
            checks++;
            if (err !== err_exp) begin
                errors++;
                $display("FAIL err rel=%0d: err=%b required=%b", rel, err, err_exp);
            end
            r_rd[rel] = rd_en; r_a[rel] = rd_addr_a; r_b[rel] = rd_addr_b; r_tw[rel] = tw_addr;
            r_wr[rel] = wr_en; r_wa[rel] = wr_addr_a; r_wb[rel] = wr_addr_b; r_done[rel] = done;
            if (rd_en === 1'b1) rd_q.push_back(rel);
            if (wr_en === 1'b1) wr_q.push_back(rel);

            start = hold && (rel <= L);
            bf_out_valid = (reset_at >= 0 && rel > reset_at) ? 1'b0 : (e_wr[rel] && rel != drop_at);
            if (rel == drop_at && e_wr[rel]) err_exp = 1'b1;
            reset = (rel == reset_at);
            if (rel == reset_at) err_exp = 1'b0;
            if (reset_at >= 0 && rel >= reset_at + 6) break;
        end
        start = 1'b0; bf_out_valid = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        idle_cycles(3);
    endtask

    task automatic test_full_run();
        int last_wr, nwr, ndone;
        idle_cycles($urandom_range(0, 5));
        run_fft(1'b0, -1, -1);
        checks++;
        if ({r_a[1], r_b[1], r_tw[1]} !== {6'd0, 6'd32, 5'd0}) begin
            errors++;
            $display("FAIL k0_addr: a=%0d b=%0d tw=%0d required 0 32 0", r_a[1], r_b[1], r_tw[1]);
        end
        checks++;
        if ({r_a[6], r_b[6], r_tw[6]} !== {6'd5, 6'd37, 5'd5}) begin
            errors++;
            $display("FAIL k5_addr: a=%0d b=%0d tw=%0d required 5 37 5", r_a[6], r_b[6], r_tw[6]);
        end
        checks++;
        if ({r_wr[4], r_wr[5], r_wa[5], r_wb[5]} !== {1'b0, 1'b1, 6'd0, 6'd32}) begin
            errors++;
            $display("FAIL first_wr: wr4=%b wr5=%b wa=%0d wb=%0d required 0 1 0 32",
                     r_wr[4], r_wr[5], r_wa[5], r_wb[5]);
        end
        checks++;
        if ({r_rd[36], r_rd[37], r_a[53], r_b[53], r_tw[53]} !== {1'b0, 1'b1, 6'd32, 6'd48, 5'd0}) begin
            errors++;
            $display("FAIL stage1: rd36=%b rd37=%b a=%0d b=%0d tw=%0d required 0 1 32 48 0",
                     r_rd[36], r_rd[37], r_a[53], r_b[53], r_tw[53]);
        end
        checks++;
        if ({r_a[184], r_b[184], r_tw[184]} !== {6'd6, 6'd7, 5'd0}) begin
            errors++;
            $display("FAIL stage5_k3: a=%0d b=%0d tw=%0d required 6 7 0",
                     r_a[184], r_b[184], r_tw[184]);
        end
        last_wr = -1; nwr = 0; ndone = 0;
        for (int c = 0; c < MAXC; c++) begin
            if (r_wr[c]) begin last_wr = c; nwr++; end
            if (r_done[c]) ndone++;
        end
        checks++;
        if (last_wr != 216 || r_done[217] !== 1'b1 || nwr != 192 || ndone != 1) begin
            errors++;
            $display("FAIL totals: last_wr=%0d done217=%b wr_count=%0d done_count=%0d required 216 1 192 1",
                     last_wr, r_done[217], nwr, ndone);
        end
        // Each stage's first read must come strictly after the previous stage's last write.
        for (int s = 0; s + 1 < LOG2N; s++) begin
            checks++;
            if (rd_q.size() != N / 2 * LOG2N || wr_q.size() != N / 2 * LOG2N) begin
                errors++;
                $display("FAIL hazard_s%0d: reads=%0d writes=%0d required %0d each",
                         s, rd_q.size(), wr_q.size(), N / 2 * LOG2N);
            end else if (rd_q[(s + 1) * HALF] <= wr_q[s * HALF + HALF - 1]) begin
                errors++;
                $display("FAIL hazard_s%0d: first_read=%0d last_write=%0d required read later",
                         s, rd_q[(s + 1) * HALF], wr_q[s * HALF + HALF - 1]);
            end
        end
    endtask

    task automatic test_start_held();
        // start stays high through the done cycle; the run must not retrigger.
        idle_cycles($urandom_range(0, 3));
        run_fft(1'b1, -1, -1);
        idle_cycles(2);
    endtask

    task automatic test_back_to_back();
        // Start again in the first idle cycle after a run.
        run_fft(1'b0, -1, -1);
        run_fft(1'b0, -1, -1);
    endtask

    task automatic test_reset_mid();
        run_fft(1'b0, -1, 50);
        run_fft(1'b0, -1, -1);
        run_fft(1'b0, -1, $urandom_range(2, L - 1));
        idle_cycles(2);
    endtask

    task automatic test_err();
        run_fft(1'b0, 5 + (36 * $urandom_range(0, LOG2N - 1)) + $urandom_range(0, HALF - 1), -1);
        idle_cycles(3);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b required=1", err);
        end
        apply_reset();
        idle_cycles(2);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; bf_out_valid = 1'b0;
        test_reset();
        test_full_run();
        test_start_held();
        test_back_to_back();
        test_reset_mid();
        test_err();
        test_full_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_stage_sequencer.md
FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 Parameter N, default 64, FFT length; power of two, 4..1024.
REQ-002 Parameter LOG2N, default 6, log2(N).
REQ-003 Parameter RD_LATENCY, default 1, data-memory read latency in cycles.
REQ-004 Parameter BF_LATENCY, default 3, butterfly enable-to-out_valid latency in cycles.
REQ-005 clk  in  1  sole clock, all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to run a full in-place radix-2 DIF FFT.
REQ-008 bf_out_valid  in  1  out_valid from the butterfly.
REQ-009 rd_en  out  1  data-memory read strobe for both ports.
REQ-010 rd_addr_a, rd_addr_b  out  LOG2N each  butterfly input addresses.
REQ-011 tw_addr  out  LOG2N-1  twiddle ROM index; ROM shares the memory read latency.
REQ-012 bf_enable  out  1  butterfly enable.
REQ-013 wr_en  out  1  data-memory write strobe for both ports.
REQ-014 wr_addr_a, wr_addr_b  out  LOG2N each  write addresses for butterfly X and Y.
REQ-015 busy  out  1  high from start acceptance through the done cycle, exclusive.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 err  out  1  sticky pipeline-mismatch flag.

Function
REQ-018 FSM states: IDLE, ISSUE, DRAIN, FINISH.
REQ-019 IDLE: start=1 -> ISSUE, stage s=0, butterfly counter k=0; start is ignored in every other state.
REQ-020 ISSUE: one butterfly per cycle with rd_en=1; k increments; at k=N/2-1 -> DRAIN.
REQ-021 Address rule for stage s, span = N>>(s+1), pos = k mod span, grp = k div span: rd_addr_a = grp*2*span+pos, rd_addr_b = rd_addr_a+span, tw_addr = pos<<s.
REQ-022 D = RD_LATENCY+BF_LATENCY; a delay line of depth D carries valid and both addresses; wr_en/wr_addr_a/wr_addr_b are its output.
REQ-023 bf_enable equals rd_en delayed by RD_LATENCY cycles.
REQ-024 DRAIN: waits until the last write of stage s has occurred (D cycles after the last issue), so no read of stage s+1 precedes any write of stage s.
REQ-025 DRAIN exit: s<LOG2N-1 -> s++, k=0, ISSUE in the cycle after the last write; s=LOG2N-1 -> FINISH.
REQ-026 FINISH: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE.
REQ-027 Timing for start sampled in cycle T: stage-s issues occupy T+1+s*(N/2+D) onward; the final wr_en is in T+LOG2N*(N/2+D); done is in the next cycle.
REQ-028 Whenever bf_out_valid differs from the delay-line valid at the same delay, err is set; it clears only on reset.
REQ-029 When rd_en=0, rd_addr_a, rd_addr_b and tw_addr are 0; when wr_en=0, wr_addr_a and wr_addr_b are 0.
REQ-030 Counters are sized exactly: k is LOG2N-1 bits and s is ceil(log2(LOG2N)) bits; no wrap occurs inside a stage.
REQ-031 A start that coincides with done (FINISH state) is ignored.

Reset
REQ-032 reset=1 forces IDLE, s=0, k=0, clears the delay line, and drives every output to 0 (including err) in the following cycle.
REQ-033 Reset mid-operation abandons the FFT: no further wr_en or done is issued, and the next start begins again at stage 0.

Verification
REQ-034 N=64, start at T -> rd_en high T+1..T+32; k=0: a=0, b=32, tw=0; k=5: a=5, b=37, tw=5; first wr_en at T+5 with wr_addr_a=0, wr_addr_b=32.
REQ-035 N=64 full run -> stage-1 first issue at T+37: a=32 appears at k=16 with b=48, tw=0; stage-5 k=3 gives a=6, b=7, tw=0; last wr_en at T+216; done at T+217; exactly 192 wr_en cycles in total.
REQ-036 Drain hazard check -> for every stage, the cycle of the first read of stage s+1 is greater than the cycle of the last write of stage s.
REQ-037 start held high through the whole run -> exactly one FFT executes, done pulses once, and a second run starts only if start is high while in IDLE.
REQ-038 reset asserted at T+50 -> all outputs 0 from T+51, no wr_en or done afterwards; a later start reproduces the scenario REQ-034 timing.
REQ-039 bf_out_valid forced low for one expected-valid cycle -> err=1 on the next cycle and it stays set until reset.
